// File: rtl/z80fi_insn_recorder.sv
// z80fi instruction recorder: gathers one instruction's fetches, data bus
// accesses and M/T-cycle profile, then emits it as one record.
module z80fi_insn_recorder #(
   parameter int INSN_BYTES  = 4,
   parameter int MAX_MCYCLES = 7
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    insn_start,
   input  logic [15:0]             ip_in,
   input  logic                    fetch_valid,
   input  logic [7:0]              fetch_byte,
   input  logic                    mcycle_valid,
   input  logic [2:0]              mcycle_type,
   input  logic                    tcycle_tick,
   input  logic                    mem_rd_valid,
   input  logic [15:0]             mem_rd_addr,
   input  logic [7:0]              mem_rd_data,
   input  logic                    mem_wr_valid,
   input  logic [15:0]             mem_wr_addr,
   input  logic [7:0]              mem_wr_data,
   input  logic                    insn_end,
   input  logic [15:0]             ip_out,
   output logic                    z80fi_valid,
   output logic [8*INSN_BYTES-1:0] z80fi_insn,
   output logic [2:0]              z80fi_insn_len,
   output logic [15:0]             z80fi_bus_raddr,
   output logic [7:0]              z80fi_bus_rdata,
   output logic [15:0]             z80fi_bus_waddr,
   output logic [7:0]              z80fi_bus_wdata,
   output logic [15:0]             z80fi_reg_ip_in,
   output logic [15:0]             z80fi_reg_ip_out,
   output logic [2:0]              z80fi_mcycle_type1,
   output logic [2:0]              z80fi_mcycle_type2,
   output logic [2:0]              z80fi_mcycle_type3,
   output logic [2:0]              z80fi_mcycle_type4,
   output logic [2:0]              z80fi_mcycle_type5,
   output logic [2:0]              z80fi_mcycle_type6,
   output logic [2:0]              z80fi_mcycle_type7,
   output logic [2:0]              z80fi_tcycles1,
   output logic [2:0]              z80fi_tcycles2,
   output logic [2:0]              z80fi_tcycles3,
   output logic [2:0]              z80fi_tcycles4,
   output logic [2:0]              z80fi_tcycles5,
   output logic [2:0]              z80fi_tcycles6,
   output logic                    z80fi_err
);

   localparam logic [2:0] CYCLE_NONE = 3'd0;

   typedef enum logic {S_IDLE, S_CAPTURE} state_t;

   state_t                  r_state;
   logic [8*INSN_BYTES-1:0] r_insn, w_insn;
   logic [2:0]              r_len, w_len;
   logic [2:0]              r_idx, w_idx;
   logic [2:0]              r_type [1:MAX_MCYCLES];
   logic [2:0]              w_type [1:MAX_MCYCLES];
   logic [2:0]              r_tc [1:MAX_MCYCLES-1];
   logic [2:0]              w_tc [1:MAX_MCYCLES-1];
   logic                    r_rd_seen, w_rd_seen;
   logic                    r_wr_seen, w_wr_seen;
   logic                    r_err, w_err;
   logic [15:0]             r_raddr, w_raddr;
   logic [15:0]             r_waddr, w_waddr;
   logic [7:0]              r_rdata, w_rdata;
   logic [7:0]              r_wdata, w_wdata;
   logic [15:0]             r_ip_in;
   logic [2:0]              r_o_type [1:MAX_MCYCLES];
   logic [2:0]              r_o_tc [1:MAX_MCYCLES-1];
   logic                    w_emit, w_clr;

   always_comb begin
      w_emit    = (r_state == S_CAPTURE) && insn_end;
      w_clr     = insn_start && !w_emit;
      w_insn    = w_clr ? '0 : r_insn;
      w_len     = w_clr ? 3'd0 : r_len;
      w_idx     = w_clr ? 3'd0 : r_idx;
      w_err     = w_clr ? 1'b0 : r_err;
      w_rd_seen = w_clr ? 1'b0 : r_rd_seen;
      w_wr_seen = w_clr ? 1'b0 : r_wr_seen;
      w_raddr   = w_clr ? 16'd0 : r_raddr;
      w_rdata   = w_clr ? 8'd0 : r_rdata;
      w_waddr   = w_clr ? 16'd0 : r_waddr;
      w_wdata   = w_clr ? 8'd0 : r_wdata;
      for (int i = 1; i <= MAX_MCYCLES; i++)
         w_type[i] = w_clr ? CYCLE_NONE : r_type[i];
      for (int i = 1; i < MAX_MCYCLES; i++)
         w_tc[i] = w_clr ? 3'd0 : r_tc[i];

      if (fetch_valid) begin
         if (w_len == 3'(INSN_BYTES)) begin
            w_err = 1'b1;
         end else begin
            for (int i = 0; i < INSN_BYTES; i++)
               if (w_len == 3'(i)) w_insn[8*i +: 8] = fetch_byte;
            w_len = w_len + 3'd1;
         end
      end

      if (mcycle_valid) begin
         if (w_idx == 3'(MAX_MCYCLES)) begin
            w_err = 1'b1;
         end else begin
            w_idx = w_idx + 3'd1;
            for (int i = 1; i <= MAX_MCYCLES; i++)
               if (w_idx == 3'(i)) w_type[i] = mcycle_type;
         end
      end

      // Index is already advanced, so a same-clock tick lands in the new slot
      if (tcycle_tick)
         for (int i = 1; i < MAX_MCYCLES; i++)
            if (w_idx == 3'(i) && w_tc[i] != 3'd7)
               w_tc[i] = w_tc[i] + 3'd1;

      if (mem_rd_valid && !w_rd_seen) begin
         w_rd_seen = 1'b1;
         w_raddr   = mem_rd_addr;
         w_rdata   = mem_rd_data;
      end
      if (mem_wr_valid && !w_wr_seen) begin
         w_wr_seen = 1'b1;
         w_waddr   = mem_wr_addr;
         w_wdata   = mem_wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state          <= S_IDLE;
         r_insn           <= '0;
         r_len            <= 3'd0;
         r_idx            <= 3'd0;
         r_err            <= 1'b0;
         r_rd_seen        <= 1'b0;
         r_wr_seen        <= 1'b0;
         r_raddr          <= 16'd0;
         r_rdata          <= 8'd0;
         r_waddr          <= 16'd0;
         r_wdata          <= 8'd0;
         r_ip_in          <= 16'd0;
         z80fi_valid      <= 1'b0;
         z80fi_insn       <= '0;
         z80fi_insn_len   <= 3'd0;
         z80fi_bus_raddr  <= 16'd0;
         z80fi_bus_rdata  <= 8'd0;
         z80fi_bus_waddr  <= 16'd0;
         z80fi_bus_wdata  <= 8'd0;
         z80fi_reg_ip_in  <= 16'd0;
         z80fi_reg_ip_out <= 16'd0;
         z80fi_err        <= 1'b0;
         for (int i = 1; i <= MAX_MCYCLES; i++) begin
            r_type[i]   <= CYCLE_NONE;
            r_o_type[i] <= CYCLE_NONE;
         end
         for (int i = 1; i < MAX_MCYCLES; i++) begin
            r_tc[i]   <= 3'd0;
            r_o_tc[i] <= 3'd0;
         end
      end else begin
         z80fi_valid <= w_emit;
         if (w_emit) begin
            z80fi_insn       <= w_insn;
            z80fi_insn_len   <= w_len;
            z80fi_bus_raddr  <= w_raddr;
            z80fi_bus_rdata  <= w_rdata;
            z80fi_bus_waddr  <= w_waddr;
            z80fi_bus_wdata  <= w_wdata;
            z80fi_reg_ip_in  <= r_ip_in;
            z80fi_reg_ip_out <= ip_out;
            z80fi_err        <= w_err;
            for (int i = 1; i <= MAX_MCYCLES; i++)
               r_o_type[i] <= w_type[i];
            for (int i = 1; i < MAX_MCYCLES; i++)
               r_o_tc[i] <= w_tc[i];
         end

         if (insn_start) begin
            r_state <= S_CAPTURE;
            r_ip_in <= ip_in;
         end else if (w_emit) begin
            r_state <= S_IDLE;
         end

         if (insn_start || r_state == S_CAPTURE) begin
            r_insn    <= w_insn;
            r_len     <= w_len;
            r_idx     <= w_idx;
            r_err     <= w_err;
            r_rd_seen <= w_rd_seen;
            r_wr_seen <= w_wr_seen;
            r_raddr   <= w_raddr;
            r_rdata   <= w_rdata;
            r_waddr   <= w_waddr;
            r_wdata   <= w_wdata;
            for (int i = 1; i <= MAX_MCYCLES; i++)
               r_type[i] <= w_type[i];
            for (int i = 1; i < MAX_MCYCLES; i++)
               r_tc[i] <= w_tc[i];
         end

         // Back-to-back: the retiring clock's events belong to the old record
         if (insn_start && w_emit) begin
            r_insn    <= '0;
            r_len     <= 3'd0;
            r_idx     <= 3'd0;
            r_err     <= 1'b0;
            r_rd_seen <= 1'b0;
            r_wr_seen <= 1'b0;
            r_raddr   <= 16'd0;
            r_rdata   <= 8'd0;
            r_waddr   <= 16'd0;
            r_wdata   <= 8'd0;
            for (int i = 1; i <= MAX_MCYCLES; i++)
               r_type[i] <= CYCLE_NONE;
            for (int i = 1; i < MAX_MCYCLES; i++)
               r_tc[i] <= 3'd0;
         end
      end
   end

   assign z80fi_mcycle_type1 = r_o_type[1];
   assign z80fi_mcycle_type2 = r_o_type[2];
   assign z80fi_mcycle_type3 = r_o_type[3];
   assign z80fi_mcycle_type4 = r_o_type[4];
   assign z80fi_mcycle_type5 = r_o_type[5];
   assign z80fi_mcycle_type6 = r_o_type[6];
   assign z80fi_mcycle_type7 = r_o_type[7];
   assign z80fi_tcycles1     = r_o_tc[1];
   assign z80fi_tcycles2     = r_o_tc[2];
   assign z80fi_tcycles3     = r_o_tc[3];
   assign z80fi_tcycles4     = r_o_tc[4];
   assign z80fi_tcycles5     = r_o_tc[5];
   assign z80fi_tcycles6     = r_o_tc[6];

endmodule
